// File: rtl/secuenciador_lectura_bcd.sv
// Fetches the 32 glyph rows of a 2-digit BCD byte from the character ROM
// and hands them, row by row, to the pixel serializer.
module secuenciador_lectura_bcd #(
    parameter int FILAS   = 16,
    parameter int ROM_LAT = 1,
    parameter int ANCHO   = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             inicio,
    input  logic [7:0]       dato_bcd,
    output logic             selector,
    input  logic [10:0]      direccion_dec,
    output logic             rom_en,
    output logic [10:0]      rom_addr,
    input  logic [ANCHO-1:0] rom_data,
    output logic [ANCHO-1:0] fila_dato,
    output logic             fila_valida,
    input  logic             fila_listo,
    output logic [3:0]       fila_idx,
    output logic             digito,
    output logic             ocupado,
    output logic             fin,
    output logic             error_bcd
);
    localparam int CW = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;
    localparam logic [CW-1:0] LAT_FIN = CW'(ROM_LAT - 1);
    localparam logic [3:0] ULTIMA = 4'(FILAS - 1);

    typedef enum logic [2:0] {
        REPOSO,
        FIJAR,
        LEER,
        ESPERA,
        ENTREGA
    } estado_t;

    estado_t          estado, estado_d;
    logic [7:0]       dato_q, dato_d;
    logic [10:0]      base_q, base_d;
    logic [3:0]       fila_q, fila_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [ANCHO-1:0] fdato_d;
    logic             sel_d, blanco_q, blanco_d, fin_d, err_d;
    logic [3:0]       nibble;

    assign nibble      = selector ? dato_q[7:4] : dato_q[3:0];
    assign rom_addr    = base_q + {7'd0, fila_q};
    assign rom_en      = (estado == LEER) && !blanco_q;
    assign fila_valida = (estado == ENTREGA);
    assign fila_idx    = fila_q;
    assign digito      = selector;
    assign ocupado     = (estado != REPOSO);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            estado    <= REPOSO;
            dato_q    <= '0;
            selector  <= 1'b0;
            base_q    <= '0;
            fila_q    <= '0;
            cnt_q     <= '0;
            blanco_q  <= 1'b0;
            fila_dato <= '0;
            fin       <= 1'b0;
            error_bcd <= 1'b0;
        end else begin
            estado    <= estado_d;
            dato_q    <= dato_d;
            selector  <= sel_d;
            base_q    <= base_d;
            fila_q    <= fila_d;
            cnt_q     <= cnt_d;
            blanco_q  <= blanco_d;
            fila_dato <= fdato_d;
            fin       <= fin_d;
            error_bcd <= err_d;
        end
    end

    always_comb begin
        estado_d = estado;
        dato_d   = dato_q;
        sel_d    = selector;
        base_d   = base_q;
        fila_d   = fila_q;
        cnt_d    = cnt_q;
        blanco_d = blanco_q;
        fdato_d  = fila_dato;
        fin_d    = 1'b0;
        err_d    = error_bcd;
        unique case (estado)
            REPOSO: begin
                if (inicio) begin
                    dato_d   = dato_bcd;
                    err_d    = 1'b0;
                    sel_d    = 1'b1;
                    fila_d   = '0;
                    estado_d = FIJAR;
                end
            end
            FIJAR: begin
                // A non-decimal nibble becomes a blank digit with normal timing
                base_d   = direccion_dec;
                blanco_d = (nibble > 4'd9);
                if (nibble > 4'd9) err_d = 1'b1;
                estado_d = LEER;
            end
            LEER: begin
                cnt_d    = '0;
                estado_d = ESPERA;
            end
            ESPERA: begin
                if (cnt_q == LAT_FIN) begin
                    fdato_d  = blanco_q ? '0 : rom_data;
                    estado_d = ENTREGA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ENTREGA: begin
                if (fila_listo) begin
                    if (fila_q != ULTIMA) begin
                        fila_d   = fila_q + 4'd1;
                        estado_d = LEER;
                    end else if (selector) begin
                        fila_d   = '0;
                        sel_d    = 1'b0;
                        estado_d = FIJAR;
                    end else begin
                        fila_d   = '0;
                        fin_d    = 1'b1;
                        estado_d = REPOSO;
                    end
                end
            end
            default: estado_d = REPOSO;
        endcase
    end
endmodule
